// File: rtl/zigzag_pingpong_ctrl_if.sv
// Handshake and SRAM bank bus between the ping-pong scan controller and its surroundings.
// The controller uses the master modport; the source/sink/SRAM side uses slave.
interface zigzag_pingpong_ctrl_if #(
  parameter int AW = 6
);
  logic          in_vld;
  logic          in_rdy;
  logic [1:0]    scan_mode;
  logic          out_rdy;
  logic          out_vld;
  logic          out_sel;
  logic          out_last;
  logic          blk_done;
  logic          b0_cs_n;
  logic          b1_cs_n;
  logic          b0_w_en;
  logic          b1_w_en;
  logic          b0_r_en;
  logic          b1_r_en;
  logic [AW-1:0] b0_addr;
  logic [AW-1:0] b1_addr;

  modport master (
    input  in_vld, scan_mode, out_rdy,
    output in_rdy, out_vld, out_sel, out_last, blk_done,
           b0_cs_n, b1_cs_n, b0_w_en, b1_w_en, b0_r_en, b1_r_en, b0_addr, b1_addr
  );

  modport slave (
    output in_vld, scan_mode, out_rdy,
    input  in_rdy, out_vld, out_sel, out_last, blk_done,
           b0_cs_n, b1_cs_n, b0_w_en, b1_w_en, b0_r_en, b1_r_en, b0_addr, b1_addr
  );
endinterface

// File: rtl/zigzag_pingpong_ctrl.sv
// Ping-pong sequencer for two 64-entry SRAM banks holding 8x8 coefficient blocks:
// raster-order writes into one bank while the other is read in zigzag/raster/column order.
module zigzag_pingpong_ctrl #(
  parameter int AW    = 6,
  parameter int NBANK = 2
) (
  input logic                    clk,
  input logic                    rst,
  zigzag_pingpong_ctrl_if.master bus
);

  localparam logic [5:0] ZZ_ROM [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic             wr_bank;
  logic             rd_bank;
  logic [AW-1:0]    wr_cnt;
  logic [AW-1:0]    rd_cnt;
  logic [NBANK-1:0] full;
  logic [NBANK-1:0] full_next;
  logic [1:0]       mode [NBANK];
  logic             out_vld_q;
  logic             out_sel_q;
  logic             out_last_q;

  logic             wr_fire;
  logic             rd_issue;
  logic             wr_last;
  logic             rd_last;
  logic [AW-1:0]    scan_addr;

  assign bus.in_rdy = !full[wr_bank];
  assign wr_fire    = bus.in_vld && bus.in_rdy;
  assign rd_issue   = full[rd_bank] && (!out_vld_q || bus.out_rdy);
  assign wr_last    = (wr_cnt == '1);
  assign rd_last    = (rd_cnt == '1);

  always_comb begin
    scan_addr = '0;
    case (mode[rd_bank])
      2'd1:    scan_addr = rd_cnt;
      2'd2:    scan_addr = {rd_cnt[2:0], rd_cnt[5:3]};
      default: scan_addr = ZZ_ROM[rd_cnt];
    endcase
  end

  // A finishing write and a finishing read always hit different banks, so both updates apply.
  always_comb begin
    full_next = full;
    if (wr_fire && wr_last)
      full_next[wr_bank] = 1'b1;
    if (rd_issue && rd_last)
      full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      full       <= '0;
      out_vld_q  <= 1'b0;
      out_sel_q  <= 1'b0;
      out_last_q <= 1'b0;
      for (int i = 0; i < NBANK; i++)
        mode[i] <= 2'd0;
    end else begin
      full      <= full_next;
      out_vld_q <= rd_issue || (out_vld_q && !bus.out_rdy);
      if (wr_fire) begin
        wr_cnt <= wr_cnt + AW'(1);
        if (wr_cnt == '0)
          mode[wr_bank] <= (bus.scan_mode == 2'd3) ? 2'd0 : bus.scan_mode;
        if (wr_last)
          wr_bank <= ~wr_bank;
      end
      if (rd_issue) begin
        rd_cnt     <= rd_cnt + AW'(1);
        out_sel_q  <= rd_bank;
        out_last_q <= rd_last;
        if (rd_last)
          rd_bank <= ~rd_bank;
      end
    end
  end

  assign bus.out_vld  = out_vld_q;
  assign bus.out_sel  = out_sel_q;
  assign bus.out_last = out_last_q;
  assign bus.blk_done = out_vld_q && bus.out_rdy && out_last_q;

  // Bank strobes are combinational so the SRAM samples them on the handshake edge.
  assign bus.b0_w_en = wr_fire && !wr_bank;
  assign bus.b1_w_en = wr_fire && wr_bank;
  assign bus.b0_r_en = rd_issue && !rd_bank;
  assign bus.b1_r_en = rd_issue && rd_bank;
  assign bus.b0_cs_n = !(bus.b0_w_en || bus.b0_r_en);
  assign bus.b1_cs_n = !(bus.b1_w_en || bus.b1_r_en);
  assign bus.b0_addr = bus.b0_w_en ? wr_cnt : (bus.b0_r_en ? scan_addr : '0);
  assign bus.b1_addr = bus.b1_w_en ? wr_cnt : (bus.b1_r_en ? scan_addr : '0);

endmodule

// File: tb/tb_zigzag_pingpong_ctrl.sv
// Bench for zigzag_pingpong_ctrl: two behavioural SRAMs plus a block-queue model of the
// expected output stream, compared every cycle, with literal pins on key values.
module tb_zigzag_pingpong_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zigzag_pingpong_ctrl_if #(.AW(6)) bus ();

  zigzag_pingpong_ctrl #(.AW(6), .NBANK(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural SRAMs: synchronous write, registered read that holds while r_en is low.
  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];
  logic [15:0] dout0;
  logic [15:0] dout1;
  always @(posedge clk) begin
    if (!bus.b0_cs_n && bus.b0_w_en) mem0[bus.b0_addr] <= in_data;
    if (!bus.b0_cs_n && bus.b0_r_en) dout0 <= mem0[bus.b0_addr];
    if (!bus.b1_cs_n && bus.b1_w_en) mem1[bus.b1_addr] <= in_data;
    if (!bus.b1_cs_n && bus.b1_r_en) dout1 <= mem1[bus.b1_addr];
  end

  // Model state: a flat queue of every complete, not-yet-issued coefficient in scan order.
  int          zz [64];
  logic [15:0] wbuf [64];
  int          wcnt, wmode, rd_idx, rd_blocks;
  logic [15:0] blkq [$];
  logic        m_vld, m_last, m_sel;
  logic [15:0] m_data;

  logic [15:0] seen [$];
  logic        sel_seen [$];
  int          last_wr_cyc, first_vld_cyc, last_vld_cyc, vld_cnt, rdy_drop, done_cnt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int scan_idx(input int m, input int k);
    if (m == 1) return k;
    if (m == 2) return (k % 8) * 8 + k / 8;
    return zz[k];
  endfunction

  // Zigzag built by walking anti-diagonals, independent of any lookup table.
  initial begin
    int r, c;
    r = 0; c = 0;
    for (int k = 0; k < 64; k++) begin
      zz[k] = r * 8 + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  end

  function automatic logic model_in_rdy();
    return ((blkq.size() + 63) / 64) < 2;
  endfunction

  task automatic model_reset();
    blkq.delete();
    wcnt = 0; wmode = 0; rd_idx = 0; rd_blocks = 0;
    m_vld = 1'b0; m_last = 1'b0; m_sel = 1'b0; m_data = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      logic exp_rdy, wr_fire, issue;
      logic [15:0] dout;
      exp_rdy = model_in_rdy();
      dout    = bus.out_sel ? dout1 : dout0;
      checkOutput("in_rdy", {31'd0, bus.in_rdy}, {31'd0, exp_rdy});
      checkOutput("out_vld", {31'd0, bus.out_vld}, {31'd0, m_vld});
      if (m_vld) begin
        checkOutput("out_data", {16'd0, dout}, {16'd0, m_data});
        checkOutput("out_last", {31'd0, bus.out_last}, {31'd0, m_last});
        checkOutput("out_sel", {31'd0, bus.out_sel}, {31'd0, m_sel});
      end
      checkOutput("blk_done", {31'd0, bus.blk_done}, {31'd0, m_vld && bus.out_rdy && m_last});
      checkOutput("wr_strobe", {31'd0, bus.b0_w_en | bus.b1_w_en}, {31'd0, bus.in_vld && exp_rdy});
      checkOutput("bank_conflict", {30'd0, bus.b0_w_en & bus.b0_r_en, bus.b1_w_en & bus.b1_r_en}, 32'd0);

      if (bus.out_vld && bus.out_rdy) begin
        seen.push_back(dout);
        sel_seen.push_back(bus.out_sel);
      end
      if (bus.out_vld) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        last_vld_cyc = cyc;
        vld_cnt++;
      end
      if (bus.in_vld && !bus.in_rdy) rdy_drop++;
      if (bus.blk_done) done_cnt++;

      wr_fire = bus.in_vld && exp_rdy;
      issue   = (blkq.size() > 0) && (!m_vld || bus.out_rdy);
      if (issue) begin
        m_data = blkq.pop_front();
        m_last = (rd_idx == 63);
        m_sel  = rd_blocks[0];
        m_vld  = 1'b1;
        rd_idx++;
        if (rd_idx == 64) begin
          rd_idx = 0;
          rd_blocks++;
        end
      end else if (bus.out_rdy) begin
        m_vld = 1'b0;
      end
      if (wr_fire) begin
        if (wcnt == 0) wmode = (bus.scan_mode == 2'd3) ? 0 : int'(bus.scan_mode);
        if (wcnt == 63) last_wr_cyc = cyc;
        wbuf[wcnt] = in_data;
        wcnt++;
        if (wcnt == 64) begin
          for (int k = 0; k < 64; k++) blkq.push_back(wbuf[scan_idx(wmode, k)]);
          wcnt = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input int n, input logic [15:0] base, input logic [1:0] m0,
                               input int sw_at, input logic [1:0] m1);
    int acc = 0;
    int budget = 0;
    while (acc < n && budget < 3000) begin
      bus.in_vld    = 1'b1;
      in_data       = base + 16'(acc);
      bus.scan_mode = (acc >= sw_at) ? m1 : m0;
      @(negedge clk);
      if (bus.in_rdy) acc++;
      @(posedge clk); #1;
      budget++;
    end
    bus.in_vld = 1'b0;
    if (acc < n) checkOutput("write_timeout", acc, n);
  endtask

  task automatic wait_drain(input bit toggle);
    int b = 0;
    while ((blkq.size() != 0 || m_vld) && b < 3000) begin
      if (toggle) bus.out_rdy = ~bus.out_rdy;
      @(posedge clk); #1;
      b++;
    end
    if (b >= 3000) checkOutput("drain_timeout", 0, 1);
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    seen.delete();
    sel_seen.delete();
    last_wr_cyc = -1; first_vld_cyc = -1; last_vld_cyc = -1;
    vld_cnt = 0; rdy_drop = 0; done_cnt = 0;
  endtask

  task automatic check_reset_values();
    checkOutput("rst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
    checkOutput("rst_out_vld", {31'd0, bus.out_vld}, 32'd0);
    checkOutput("rst_out_sel", {31'd0, bus.out_sel}, 32'd0);
    checkOutput("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    checkOutput("rst_blk_done", {31'd0, bus.blk_done}, 32'd0);
    checkOutput("rst_cs_n", {30'd0, bus.b0_cs_n, bus.b1_cs_n}, 32'd3);
    checkOutput("rst_en", {28'd0, bus.b0_w_en, bus.b1_w_en, bus.b0_r_en, bus.b1_r_en}, 32'd0);
    checkOutput("rst_addr", {20'd0, bus.b0_addr, bus.b1_addr}, 32'd0);
  endtask

  initial begin
    int acc, first_ref;
    rst = 1'b1;
    bus.in_vld = 1'b0;
    bus.scan_mode = 2'd0;
    bus.out_rdy = 1'b1;
    in_data = '0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values();

    // Partial block then a 2-cycle reset: nothing from it may ever appear.
    applyStimulus(20, 16'd500, 2'd0, 64, 2'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values();

    $display("[TB] zigzag block");
    clear_obs();
    applyStimulus(64, 16'd0, 2'd0, 64, 2'd0);
    wait_drain(1'b0);
    checkOutput("zz_count", seen.size(), 64);
    if (seen.size() == 64) begin
      checkOutput("zz_0", seen[0], 0);
      checkOutput("zz_1", seen[1], 1);
      checkOutput("zz_2", seen[2], 8);
      checkOutput("zz_3", seen[3], 16);
      checkOutput("zz_60", seen[60], 47);
      checkOutput("zz_61", seen[61], 55);
      checkOutput("zz_62", seen[62], 62);
      checkOutput("zz_63", seen[63], 63);
      checkOutput("zz_bank", {31'd0, sel_seen[0]}, 32'd0);
    end
    checkOutput("zz_latency", first_vld_cyc - last_wr_cyc, 2);
    checkOutput("zz_done", done_cnt, 1);

    $display("[TB] column block");
    clear_obs();
    applyStimulus(64, 16'd0, 2'd2, 64, 2'd2);
    wait_drain(1'b0);
    checkOutput("col_count", seen.size(), 64);
    if (seen.size() == 64) begin
      checkOutput("col_1", seen[1], 8);
      checkOutput("col_7", seen[7], 56);
      checkOutput("col_8", seen[8], 1);
      checkOutput("col_63", seen[63], 63);
    end

    $display("[TB] streaming three blocks");
    clear_obs();
    applyStimulus(192, 16'd1000, 2'd1, 192, 2'd1);
    wait_drain(1'b0);
    checkOutput("stream_count", seen.size(), 192);
    checkOutput("stream_rdy_drop", rdy_drop, 0);
    checkOutput("stream_vld_cnt", vld_cnt, 192);
    checkOutput("stream_no_gap", last_vld_cyc - first_vld_cyc + 1, 192);
    checkOutput("stream_done", done_cnt, 3);
    if (seen.size() == 192) begin
      checkOutput("stream_100", seen[100], 1100);
      checkOutput("stream_sel63", {31'd0, sel_seen[63]}, 32'd0);
      checkOutput("stream_sel64", {31'd0, sel_seen[64]}, 32'd1);
      checkOutput("stream_sel128", {31'd0, sel_seen[128]}, 32'd0);
    end

    $display("[TB] backpressure");
    clear_obs();
    bus.out_rdy = 1'b0;
    acc = 0;
    first_ref = -1;
    for (int i = 0; i < 130; i++) begin
      bus.in_vld = 1'b1;
      in_data = 16'd2000 + 16'(acc);
      bus.scan_mode = 2'd1;
      @(negedge clk);
      if (bus.in_rdy) acc++;
      else if (first_ref < 0) first_ref = i;
      @(posedge clk); #1;
    end
    bus.in_vld = 1'b0;
    checkOutput("bp_accepted", acc, 128);
    checkOutput("bp_first_refusal", first_ref, 128);
    wait_drain(1'b1);
    checkOutput("bp_count", seen.size(), 128);
    if (seen.size() == 128) begin
      checkOutput("bp_0", seen[0], 2000);
      checkOutput("bp_64", seen[64], 2064);
      checkOutput("bp_127", seen[127], 2127);
    end

    $display("[TB] mode latch");
    clear_obs();
    applyStimulus(64, 16'd3000, 2'd0, 10, 2'd1);
    applyStimulus(64, 16'd3100, 2'd1, 64, 2'd1);
    wait_drain(1'b0);
    checkOutput("latch_count", seen.size(), 128);
    if (seen.size() == 128) begin
      checkOutput("latch_zz_2", seen[2], 3008);
      checkOutput("latch_zz_3", seen[3], 3016);
      checkOutput("latch_raster_2", seen[66], 3102);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/zigzag_pingpong_ctrl.md
Name: zigzag_pingpong_ctrl

Overview:
- Sequencer for two external 64-entry SRAM64 banks used as a ping-pong buffer for 8x8 coefficient blocks.
- Accepts raster-order writes into one bank while reading the other bank in a selected scan order (zigzag, raster, column).
- Drives chip-select, write-enable, read-enable and address for both banks, plus the output valid/select/last flags.
- Sits between the block source and the entropy/serialiser stage; data does not pass through it.

Parameters:
- AW, 6, bank address width (64 entries, fixed 8x8 block).
- NBANK, 2, number of banks (ping-pong; only 2 supported).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_vld  in  1  source presents one coefficient this cycle.
- in_rdy  out  1  controller can accept a write this cycle.
- scan_mode  in  2  scan order: 0 zigzag, 1 raster, 2 column, 3 reserved (treated as 0). Sampled with the first write of each block.
- out_rdy  in  1  downstream accepts the current output.
- out_vld  out  1  selected bank's dout holds a valid coefficient.
- out_sel  out  1  bank whose dout the integrator muxes to the output.
- out_last  out  1  current output is coefficient 63 of its block.
- blk_done  out  1  one-cycle pulse when the last coefficient of a block is accepted.
- b0_cs_n, b1_cs_n  out  1 each  bank chip selects, active low.
- b0_w_en, b1_w_en  out  1 each  bank write enables.
- b0_r_en, b1_r_en  out  1 each  bank read enables.
- b0_addr, b1_addr  out  AW each  bank addresses.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Output values: in_rdy=1, out_vld=0, out_sel=0, out_last=0, blk_done=0, all cs_n=1, all w_en/r_en=0, all addr=0.
  - Internal state: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full[1:0]=0.
  - Reset mid-block discards both banks' contents logically; no partial block is ever read out.
- Enables and addresses are combinational from registered state and handshake inputs, so the SRAM samples them on the same edge as the handshake.
- Write side:
  - in_rdy = !full[wr_bank].
  - Write fires when in_vld && in_rdy: bank wr_bank gets cs_n=0, w_en=1, addr=wr_cnt (raster); wr_cnt increments.
  - On the write with wr_cnt==0, scan_mode is latched into mode[wr_bank]; scan_mode changes mid-block are ignored.
  - On the write with wr_cnt==63: full[wr_bank] sets next cycle, wr_bank toggles, wr_cnt wraps to 0.
- Read side:
  - Read issues when full[rd_bank] && (!out_vld || out_rdy): bank rd_bank gets cs_n=0, r_en=1, addr=scan(mode[rd_bank], rd_cnt); rd_cnt increments.
  - On the read with rd_cnt==63: full[rd_bank] clears next cycle, rd_bank toggles.
  - Registered outputs: out_vld_next = issue || (out_vld && !out_rdy). out_sel and out_last are registered with the issue (out_last=1 when rd_cnt was 63).
  - Stall: when out_vld && !out_rdy, no read is issued. SRAM dout holds because r_en is low, so data stays stable.
  - blk_done = out_vld && out_rdy && out_last.
- Scan mapping, index k -> raster address:
  - raster: k.
  - column: (k[2:0]<<3) | k[5:3].
  - zigzag: standard JPEG 64-entry ROM, beginning 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5 and ending 47,55,62,63.
- Latency and throughput:
  - 64th write at edge N -> full visible and first r_en at cycle N+1 -> out_vld=1 at N+2.
  - Steady state is one write and one read per cycle, with no bubbles between blocks when out_rdy=1.
- Boundary conditions:
  - Both banks full: in_rdy=0 until the read of index 63 of rd_bank issues; in_rdy returns the cycle after.
  - A write and a read in the same cycle always target different banks (full-flag invariant), so no per-bank conflict is possible.
  - Set and clear of different full bits in the same cycle are both applied.
  - in_vld while in_rdy=0: ignored, no counter change.

Test Plan:
- Reset: hold rst 2 cycles mid-stream -> all outputs at reset values, in_rdy=1; a following 64-write block reads out correctly from bank 0.
- Zigzag single block: write data=address 0..63, mode 0, out_rdy=1 -> r_en at N+1; outputs 0,1,8,16,9,2,3,10,… ending 62,63; out_last and blk_done on 63.
- Column mode: mode 2 block -> outputs 0,8,16,…,56,1,9,…,63.
- Ping-pong streaming: 3 back-to-back blocks with in_vld=1 and out_rdy=1 -> in_rdy never drops; out_sel toggles every 64 outputs; no out_vld gap.
- Full/backpressure: out_rdy=0, 130 writes offered -> exactly 128 accepted, in_rdy=0 from the 129th offer. out_rdy toggled 1/0 -> each value held while stalled, none lost or duplicated.
- Mode latch: scan_mode switched 0->1 at write 10 -> block still reads in zigzag; next block reads raster.
